// File: rtl/img_arith_pkg.sv
// Shared arithmetic helpers: clog2, stage count and signed/unsigned saturation.
// Saturation works on a fixed 64-bit signed value; the result carries a clamp flag.
package img_arith_pkg;

    localparam int unsigned SAT_W = 64;

    typedef struct packed {
        logic             sat;
        logic [SAT_W-1:0] val;
    } sat_res_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned stage_count(input int unsigned b_w, input int unsigned bps);
        return b_w / bps;
    endfunction

    // Clamp v into [-2^(w-1), 2^(w-1)-1].
    function automatic sat_res_t sat_signed(input logic signed [SAT_W-1:0] v, input int unsigned w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sat_res_t                r;
        hi = $signed((SAT_W'(1) << (w - 1)) - SAT_W'(1));
        lo = ~hi;
        r.sat = 1'b0;
        r.val = v;
        if (v > hi) begin
            r.sat = 1'b1;
            r.val = hi;
        end else if (v < lo) begin
            r.sat = 1'b1;
            r.val = lo;
        end
        return r;
    endfunction

    // Clamp v into [0, 2^w-1].
    function automatic sat_res_t sat_unsigned(input logic signed [SAT_W-1:0] v, input int unsigned w);
        logic [SAT_W-1:0] hi;
        sat_res_t         r;
        hi = (SAT_W'(1) << w) - SAT_W'(1);
        r.sat = 1'b0;
        r.val = v;
        if (v[SAT_W-1]) begin
            r.sat = 1'b1;
            r.val = '0;
        end else if ($unsigned(v) > hi) begin
            r.sat = 1'b1;
            r.val = hi;
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_pp_stage.sv
// One shift-add stage: adds |a| weighted by the next BPS bits of |b| into the accumulator.
module mult_pp_stage #(
    parameter int unsigned A_W   = 8,
    parameter int unsigned B_W   = 8,
    parameter int unsigned P_W   = 16,
    parameter int unsigned BPS   = 1,
    parameter int unsigned SHIFT = 0
) (
    input  logic           clk,
    input  logic           aresetn,
    input  logic           i_en,
    input  logic           i_valid,
    input  logic           i_sign,
    input  logic           i_mode,
    input  logic [A_W-1:0] i_a,
    input  logic [B_W-1:0] i_b,
    input  logic [P_W-1:0] i_acc,
    output logic           o_valid,
    output logic           o_sign,
    output logic           o_mode,
    output logic [A_W-1:0] o_a,
    output logic [B_W-1:0] o_b,
    output logic [P_W-1:0] o_acc
);

    logic [P_W-1:0] w_acc;

    // i_b[0] always holds the bit of original weight SHIFT.
    always_comb begin
        w_acc = i_acc;
        for (int j = 0; j < BPS; j++) begin
            if (i_b[j]) w_acc = w_acc + (P_W'(i_a) << (SHIFT + j));
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            o_valid <= 1'b0;
            o_sign  <= 1'b0;
            o_mode  <= 1'b0;
            o_a     <= '0;
            o_b     <= '0;
            o_acc   <= '0;
        end else if (i_en) begin
            o_valid <= i_valid;
            o_sign  <= i_sign;
            o_mode  <= i_mode;
            o_a     <= i_a;
            o_b     <= i_b >> BPS;
            o_acc   <= w_acc;
        end
    end

endmodule

// File: rtl/multiplier_int_stream.sv
// Pipelined sign-magnitude shift-add multiplier with valid/ready flow, scaling and saturation.
// Build option: define MULT_INT_ROUND_EN for round-half-up scaling instead of truncation.
module multiplier_int_stream
    import img_arith_pkg::*;
#(
    parameter int unsigned A_W            = 8,
    parameter int unsigned B_W            = 8,
    parameter int unsigned BITS_PER_STAGE = 1,
    parameter int unsigned OUT_SHIFT      = 0,
    parameter int unsigned OUT_W          = A_W + B_W
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [A_W-1:0]   opp_a,
    input  logic [B_W-1:0]   opp_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out,
    output logic             out_sat
);

    localparam int unsigned P_W = A_W + B_W;
    localparam int unsigned N   = stage_count(B_W, BITS_PER_STAGE);
`ifdef MULT_INT_ROUND_EN
    localparam logic [P_W:0] RND = (OUT_SHIFT == 0) ? (P_W+1)'(0)
                                 : ((P_W+1)'(1) << ((OUT_SHIFT == 0) ? 0 : OUT_SHIFT - 1));
`else
    localparam logic [P_W:0] RND = '0;
`endif

    logic             w_adv;
    logic [A_W-1:0]   w_abs_a;
    logic [B_W-1:0]   w_abs_b;
    logic             r_s0_valid, r_s0_sign, r_s0_mode;
    logic [A_W-1:0]   r_s0_a;
    logic [B_W-1:0]   r_s0_b;
    logic             r_out_valid, r_out_sat;
    logic [OUT_W-1:0] r_out;

    logic             w_v  [0:N];
    logic             w_sg [0:N];
    logic             w_md [0:N];
    logic [A_W-1:0]   w_a  [0:N];
    logic [B_W-1:0]   w_b  [0:N];
    logic [P_W-1:0]   w_acc[0:N];

    logic [P_W-1:0]          w_p;
    logic [P_W:0]            w_ext, w_sum;
    logic signed [P_W:0]     w_sh;
    logic signed [SAT_W-1:0] w_q;
    sat_res_t                w_res;
    logic                    w_unused_tail;

    // Whole pipeline moves in lockstep; a stalled output freezes every stage.
    assign w_adv     = !r_out_valid || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign out_sat   = r_out_sat;

    assign w_abs_a = (in_signed && opp_a[A_W-1]) ? A_W'(-opp_a) : opp_a;
    assign w_abs_b = (in_signed && opp_b[B_W-1]) ? B_W'(-opp_b) : opp_b;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_s0_valid <= 1'b0;
            r_s0_sign  <= 1'b0;
            r_s0_mode  <= 1'b0;
            r_s0_a     <= '0;
            r_s0_b     <= '0;
        end else if (w_adv) begin
            r_s0_valid <= in_valid;
            r_s0_sign  <= in_signed && (opp_a[A_W-1] ^ opp_b[B_W-1]);
            r_s0_mode  <= in_signed;
            r_s0_a     <= w_abs_a;
            r_s0_b     <= w_abs_b;
        end
    end

    assign w_v[0]   = r_s0_valid;
    assign w_sg[0]  = r_s0_sign;
    assign w_md[0]  = r_s0_mode;
    assign w_a[0]   = r_s0_a;
    assign w_b[0]   = r_s0_b;
    assign w_acc[0] = '0;

    for (genvar k = 0; k < N; k++) begin : g_stage
        mult_pp_stage #(
            .A_W  (A_W),
            .B_W  (B_W),
            .P_W  (P_W),
            .BPS  (BITS_PER_STAGE),
            .SHIFT(k * BITS_PER_STAGE)
        ) u_stage (
            .clk    (clk),
            .aresetn(aresetn),
            .i_en   (w_adv),
            .i_valid(w_v[k]),
            .i_sign (w_sg[k]),
            .i_mode (w_md[k]),
            .i_a    (w_a[k]),
            .i_b    (w_b[k]),
            .i_acc  (w_acc[k]),
            .o_valid(w_v[k+1]),
            .o_sign (w_sg[k+1]),
            .o_mode (w_md[k+1]),
            .o_a    (w_a[k+1]),
            .o_b    (w_b[k+1]),
            .o_acc  (w_acc[k+1])
        );
    end

    // Sign restore and scaling at one extra bit so the rounding add cannot wrap.
    always_comb begin
        w_p   = w_sg[N] ? P_W'(-w_acc[N]) : w_acc[N];
        w_ext = w_md[N] ? {w_p[P_W-1], w_p} : {1'b0, w_p};
        w_sum = w_ext + RND;
        w_sh  = $signed(w_sum) >>> OUT_SHIFT;
        w_q   = SAT_W'(w_sh);
        w_res = w_md[N] ? sat_signed(w_q, OUT_W) : sat_unsigned(w_q, OUT_W);
    end

    assign w_unused_tail = ^{w_a[N], w_b[N], w_res.val};

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_out_sat   <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= w_v[N];
            r_out       <= w_res.val[OUT_W-1:0];
            r_out_sat   <= w_res.sat;
        end
    end

endmodule

// File: tb/tb_multiplier_int_stream.sv
// Bench for multiplier_int_stream: three 4x4 configurations share one stimulus stream,
// each checked by its own scoreboard fed from an arithmetic reference model.
module tb_multiplier_int_stream;

    logic       clk = 1'b0;
    logic       aresetn = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_signed = 1'b0;
    logic       out_ready = 1'b1;
    logic [3:0] opp_a = '0;
    logic [3:0] opp_b = '0;

    logic       rdy [3];
    logic       ov  [3];
    logic       osat[3];
    logic [7:0] outs[3];
    logic [7:0] out_d;
    logic [5:0] out_s;
    logic [4:0] out_h;

    localparam int OW[3] = '{8, 6, 5};
    localparam int SH[3] = '{0, 0, 2};
`ifdef MULT_INT_ROUND_EN
    localparam int SHF_LAST = 4;
`else
    localparam int SHF_LAST = 3;
`endif
    localparam int D_S[10] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1};
    localparam int D_A[10] = '{3, 8, 7, 0, 15, 8, 15, 8, 8, 3};
    localparam int D_B[10] = '{11, 8, 7, 13, 15, 2, 15, 2, 7, 5};
    localparam int EXP_OUT[3][10] = '{
        '{-15, 64, 49, 0, 225, 16, 1, -16, -56, 15},
        '{-15, 31, 31, 0, 63, 16, 1, -16, -32, 15},
        '{-4, 15, 12, 0, 31, 4, 0, -4, -14, SHF_LAST}};
    localparam int EXP_SAT[3][10] = '{
        '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
        '{0, 1, 1, 0, 1, 0, 0, 0, 1, 0},
        '{0, 1, 0, 0, 1, 0, 0, 0, 0, 0}};

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [64:0] sb [3][$];
    logic [64:0] cap[3][$];
    int incyc[$];
    int lat[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign outs[0] = out_d;
    assign outs[1] = 8'(out_s);
    assign outs[2] = 8'(out_h);

    multiplier_int_stream #(.A_W(4), .B_W(4), .BITS_PER_STAGE(1), .OUT_SHIFT(0), .OUT_W(8)) u_dut (
        .clk(clk), .aresetn(aresetn), .in_valid(in_valid), .in_ready(rdy[0]), .in_signed(in_signed),
        .opp_a(opp_a), .opp_b(opp_b), .out_valid(ov[0]), .out_ready(out_ready), .out(out_d),
        .out_sat(osat[0]));
    multiplier_int_stream #(.A_W(4), .B_W(4), .BITS_PER_STAGE(2), .OUT_SHIFT(0), .OUT_W(6)) u_sat (
        .clk(clk), .aresetn(aresetn), .in_valid(in_valid), .in_ready(rdy[1]), .in_signed(in_signed),
        .opp_a(opp_a), .opp_b(opp_b), .out_valid(ov[1]), .out_ready(out_ready), .out(out_s),
        .out_sat(osat[1]));
    multiplier_int_stream #(.A_W(4), .B_W(4), .BITS_PER_STAGE(4), .OUT_SHIFT(2), .OUT_W(5)) u_shf (
        .clk(clk), .aresetn(aresetn), .in_valid(in_valid), .in_ready(rdy[2]), .in_signed(in_signed),
        .opp_a(opp_a), .opp_b(opp_b), .out_valid(ov[2]), .out_ready(out_ready), .out(out_h),
        .out_sat(osat[2]));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: exact integer product, scaled by floor division, then clamped.
    function automatic logic [64:0] model(input logic s, input logic [3:0] a, input logic [3:0] b,
                                          input int w, input int sh);
        longint pa, pb, p, q, hi, lo;
        logic st;
        pa = s ? longint'($signed(a)) : longint'(a);
        pb = s ? longint'($signed(b)) : longint'(b);
        p  = pa * pb;
`ifdef MULT_INT_ROUND_EN
        if (sh > 0) p = p + (64'sd1 <<< (sh - 1));
`endif
        q  = p >>> sh;
        hi = s ? ((64'sd1 <<< (w - 1)) - 1) : ((64'sd1 <<< w) - 1);
        lo = s ? -(64'sd1 <<< (w - 1)) : 64'sd0;
        st = 1'b0;
        if (q > hi) begin q = hi; st = 1'b1; end
        else if (q < lo) begin q = lo; st = 1'b1; end
        return {st, 64'(q)};
    endfunction

    function automatic logic [63:0] mask(input logic [63:0] v, input int w);
        return v & ((64'd1 << w) - 64'd1);
    endfunction

    // Handshakes are sampled mid-cycle; they complete at the following rising edge.
    always @(negedge clk) begin : mon
        logic [64:0] e;
        if (aresetn) begin
            for (int k = 0; k < 3; k++) begin
                if (ov[k] && out_ready) begin
                    cap[k].push_back({osat[k], 64'(outs[k])});
                    check($sformatf("u%0d_sb_nonempty", k), 64'(sb[k].size() != 0), 64'd1);
                    if (sb[k].size() != 0) begin
                        e = sb[k].pop_front();
                        check($sformatf("u%0d_out", k), 64'(outs[k]), mask(e[63:0], OW[k]));
                        check($sformatf("u%0d_sat", k), 64'(osat[k]), 64'(e[64]));
                    end
                    if (k == 0 && incyc.size() != 0) lat.push_back(cyc - incyc.pop_front());
                end
                if (in_valid && rdy[k]) begin
                    sb[k].push_back(model(in_signed, opp_a, opp_b, OW[k], SH[k]));
                    if (k == 0) incyc.push_back(cyc);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic put(input logic s, input logic [3:0] a, input logic [3:0] b);
        int  n;
        logic acc;
        n = 0;
        in_valid = 1'b1; in_signed = s; opp_a = a; opp_b = b;
        do begin
            @(negedge clk); acc = rdy[0];
            @(posedge clk); #1; n++;
        end while (!acc && n < 100);
        if (!acc) check("accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && n < 200) begin idle(1); n++; end
        check("drain_empty", 64'(sb[0].size() + sb[1].size() + sb[2].size()), 64'd0);
    endtask

    task automatic clear_caps();
        for (int k = 0; k < 3; k++) cap[k].delete();
        lat.delete();
    endtask

    initial begin
        int n, beats, guard;
        logic acc, held_sat;
        logic [7:0] held;
        logic [64:0] c;

        #1 aresetn = 1'b0;
        #12;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_valid%0d", k), 64'(ov[k]), 64'd0);
            check($sformatf("rst_out%0d", k), 64'(outs[k]), 64'd0);
            check($sformatf("rst_sat%0d", k), 64'(osat[k]), 64'd0);
        end
        @(posedge clk); #1 aresetn = 1'b1;
        idle(2);

        // Directed stream: signed/unsigned corners, saturation and scaling, back-to-back.
        clear_caps();
        for (int i = 0; i < 10; i++) put(1'(D_S[i]), 4'(D_A[i]), 4'(D_B[i]));
        drain();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("dir_count%0d", k), 64'(cap[k].size()), 64'd10);
            for (int i = 0; i < 10 && i < cap[k].size(); i++) begin
                c = cap[k][i];
                check($sformatf("dir_out%0d_%0d", k, i), c[63:0], mask(64'(EXP_OUT[k][i]), OW[k]));
                check($sformatf("dir_sat%0d_%0d", k, i), 64'(c[64]), 64'(EXP_SAT[k][i]));
            end
        end
        check("dir_lat_count", 64'(lat.size()), 64'd10);
        for (int i = 0; i < lat.size(); i++) check($sformatf("dir_lat%0d", i), 64'(lat[i]), 64'd6);

        // Backpressure with three beats in flight.
        put(1'b1, 4'd5, 4'd6);
        put(1'b0, 4'd9, 4'd3);
        put(1'b1, 4'd12, 4'd7);
        n = 0;
        while (!ov[0] && n < 20) begin idle(1); n++; end
        check("bp_first_valid", 64'(ov[0]), 64'd1);
        out_ready = 1'b0;
        held = outs[0];
        held_sat = osat[0];
        repeat (5) begin
            idle(1);
            check("bp_in_ready", 64'(rdy[0]), 64'd0);
            check("bp_valid", 64'(ov[0]), 64'd1);
            check("bp_hold_out", 64'(outs[0]), 64'(held));
            check("bp_hold_sat", 64'(osat[0]), 64'(held_sat));
        end
        drain();

        // Reset mid-stream: in-flight beats must vanish.
        for (int i = 0; i < 8; i++) put(1'b1, 4'(i + 1), 4'(15 - i));
        #1 aresetn = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("mid_rst_valid%0d", k), 64'(ov[k]), 64'd0);
            check($sformatf("mid_rst_out%0d", k), 64'(outs[k]), 64'd0);
        end
        for (int k = 0; k < 3; k++) sb[k].delete();
        incyc.delete();
        idle(2);
        @(posedge clk); #1 aresetn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            idle(1);
            check("no_stale", 64'(ov[0] | ov[1] | ov[2]), 64'd0);
        end
        clear_caps();
        put(1'b1, 4'd2, 4'd3);
        drain();
        check("post_rst_count", 64'(cap[0].size()), 64'd1);
        if (cap[0].size() != 0) begin
            c = cap[0][0];
            check("post_rst_out", c[63:0], 64'd6);
        end
        if (lat.size() != 0) check("post_rst_lat", 64'(lat[0]), 64'd6);

        // Random traffic with random valid/ready, biased toward corner operands.
        beats = 0;
        guard = 0;
        while (beats < 500 && guard < 20000) begin
            if (!in_valid && $urandom_range(0, 9) < 7) begin
                in_valid  = 1'b1;
                in_signed = 1'($urandom);
                opp_a = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 3) * 5) : 4'($urandom);
                opp_b = ($urandom_range(0, 3) == 0) ? 4'(8 - $urandom_range(0, 1)) : 4'($urandom);
            end
            out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk); acc = in_valid && rdy[0];
            @(posedge clk); #1; guard++;
            if (acc) begin beats++; in_valid = 1'b0; end
        end
        check("rand_beats", 64'(beats), 64'd500);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
